// File: rtl/pmaj_fanout_if.sv
// Handshake bundle for pmaj_fanout: forward majority beats and backward gradient beats.
// The master side drives the *_in signals; the slave side (the node) drives the *_out signals.
interface pmaj_fanout_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
);
    logic             fvalid_in;
    logic             fcontrol;
    logic [N_IN-1:0]  fin;
    logic             fvalid_out;
    logic [N_OUT-1:0] fout;
    logic             bvalid_in;
    logic [N_OUT-1:0] bin;
    logic             bvalid_out;
    logic             bcontrol;
    logic [N_IN-1:0]  bout;

    modport master (
        output fvalid_in, fcontrol, fin, bvalid_in, bin,
        input  fvalid_out, fout, bvalid_out, bcontrol, bout
    );

    modport slave (
        input  fvalid_in, fcontrol, fin, bvalid_in, bin,
        output fvalid_out, fout, bvalid_out, bcontrol, bout
    );
endinterface

// File: rtl/pmaj_fanout.sv
// Registered stochastic bitnet node: controlled majority fan-out forward, LFSR-selected gradient broadcast backward.
// Optional feature macro PMAJ_OSC_MIX_EN mixes a synchronised ring-oscillator bit into the LFSR.
module pmaj_fanout #(
    parameter int          N_IN   = 3,
    parameter int          N_OUT  = 2,
    parameter int          LFSR_W = 16,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          oscillator,
    pmaj_fanout_if.slave  bus
);
    localparam int          POP_W    = $clog2(N_IN + 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] MASK     = 16'hB400;

    if ((N_IN < 1) || ((N_IN % 2) == 0)) begin : g_bad_n_in
        $error("pmaj_fanout: N_IN must be odd and >= 1");
    end
    if (N_OUT < 1) begin : g_bad_n_out
        $error("pmaj_fanout: N_OUT must be >= 1");
    end
    if (LFSR_W != 16) begin : g_bad_lfsr_w
        $error("pmaj_fanout: LFSR_W must be 16");
    end

    function automatic logic [POP_W-1:0] popcount(input logic [N_IN-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
    endfunction

    logic             fvalid_r;
    logic [N_OUT-1:0] fout_r;
    logic             bvalid_r;
    logic             bcontrol_r;
    logic [N_IN-1:0]  bout_r;
    logic [15:0]      lfsr_r;
    logic [15:0]      lfsr_nxt_s;
    logic [15:0]      sel_s;
    logic             bsel_s;
    logic             maj_s;
    logic             fres_s;

    // Forward result: majority or minority of the input bits.
    always_comb begin
        maj_s  = popcount(bus.fin) > POP_W'(N_IN / 2);
        fres_s = bus.fcontrol ? maj_s : ~maj_s;
    end

    // Backward selection from the current LFSR state; a compare loop avoids a narrow dynamic index.
    always_comb begin
        sel_s  = {8'h00, lfsr_r[7:0]} % 16'(N_OUT);
        bsel_s = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (sel_s == 16'(i)) begin
                bsel_s = bus.bin[i];
            end else begin
                bsel_s = bsel_s;
            end
        end
    end

`ifdef PMAJ_OSC_MIX_EN
    logic osc_meta_r;
    logic osc_sync_r;
    logic [15:0] mix_s;

    // Two-flop synchroniser for the asynchronous oscillator bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            osc_meta_r <= 1'b0;
            osc_sync_r <= 1'b0;
        end else begin
            osc_meta_r <= oscillator;
            osc_sync_r <= osc_meta_r;
        end
    end

    // Entropy is mixed into bit 0; a zero result would lock the LFSR, so reseed instead.
    always_comb begin
        mix_s = lfsr_step(lfsr_r) ^ {15'h0000, osc_sync_r};
        if (mix_s == 16'h0000) begin
            lfsr_nxt_s = SEED_EFF;
        end else begin
            lfsr_nxt_s = mix_s;
        end
    end
`else
    logic unused_osc_s;
    assign unused_osc_s = oscillator;

    // Purely deterministic LFSR successor.
    always_comb begin
        lfsr_nxt_s = lfsr_step(lfsr_r);
    end
`endif

    // LFSR advances once per accepted backward beat.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lfsr_r <= SEED_EFF;
        end else if (bus.bvalid_in) begin
            lfsr_r <= lfsr_nxt_s;
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Forward pipeline register; data holds when no beat arrives.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fvalid_r <= 1'b0;
            fout_r   <= '0;
        end else begin
            fvalid_r <= bus.fvalid_in;
            if (bus.fvalid_in) begin
                fout_r <= {N_OUT{fres_s}};
            end else begin
                fout_r <= fout_r;
            end
        end
    end

    // Backward pipeline register; data holds when no beat arrives.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bvalid_r   <= 1'b0;
            bcontrol_r <= 1'b0;
            bout_r     <= '0;
        end else begin
            bvalid_r <= bus.bvalid_in;
            if (bus.bvalid_in) begin
                bcontrol_r <= bsel_s;
                bout_r     <= {N_IN{bsel_s}};
            end else begin
                bcontrol_r <= bcontrol_r;
                bout_r     <= bout_r;
            end
        end
    end

    assign bus.fvalid_out = fvalid_r;
    assign bus.fout       = fout_r;
    assign bus.bvalid_out = bvalid_r;
    assign bus.bcontrol   = bcontrol_r;
    assign bus.bout       = bout_r;
endmodule

// File: tb/tb_pmaj_fanout.sv
// Self-checking bench for pmaj_fanout: a default (3/2) instance and a 5/3 instance driven side by side,
// with expected beats pushed to scoreboard queues at drive time and popped when the outputs appear.
module tb_pmaj_fanout;
    logic clk;
    logic rst_n;
    logic osc;
    int   total;
    int   bad;

    pmaj_fanout_if #(.N_IN(3), .N_OUT(2)) if0 ();
    pmaj_fanout_if #(.N_IN(5), .N_OUT(3)) if1 ();

    pmaj_fanout #(.N_IN(3), .N_OUT(2)) d0 (
        .clk_in(clk), .rst_n_in(rst_n), .oscillator(osc), .bus(if0)
    );
    pmaj_fanout #(.N_IN(5), .N_OUT(3)) d1 (
        .clk_in(clk), .rst_n_in(rst_n), .oscillator(osc), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial osc = 1'b0;
    always #7 osc = ~osc;

    logic [7:0]  fq0[$];
    logic [7:0]  bq0[$];
    logic [7:0]  fq1[$];
    logic [7:0]  bq1[$];
    logic [7:0]  lf0, lb0, lf1, lb1;
    logic [15:0] m0, m1;

    function automatic logic [15:0] lstep(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq0.delete(); bq0.delete(); fq1.delete(); bq1.delete();
        lf0 = 8'h00; lb0 = 8'h00; lf1 = 8'h00; lb1 = 8'h00;
        m0 = 16'hACE1; m1 = 16'hACE1;
    endtask

    // One beat: drive, record expectations, let one rising edge pass, check at the falling edge.
    task automatic step(input logic fv, input logic fc, input logic [2:0] f0, input logic [4:0] f1,
                        input logic bv, input logic [1:0] b0, input logic [2:0] b1);
        logic r0, r1, x0, x1;
        int   s0, s1;
        if0.fvalid_in = fv; if0.fcontrol = fc; if0.fin = f0; if0.bvalid_in = bv; if0.bin = b0;
        if1.fvalid_in = fv; if1.fcontrol = fc; if1.fin = f1; if1.bvalid_in = bv; if1.bin = b1;
        if (fv) begin
            r0 = ($countones(f0) > 1) ? fc : ~fc;
            r1 = ($countones(f1) > 2) ? fc : ~fc;
            fq0.push_back({6'b0, {2{r0}}});
            fq1.push_back({5'b0, {3{r1}}});
        end
        if (bv) begin
            s0 = int'(m0[7:0]) % 2;
            s1 = int'(m1[7:0]) % 3;
            x0 = b0[s0];
            x1 = b1[s1];
            bq0.push_back({4'b0, x0, {3{x0}}});
            bq1.push_back({2'b0, x1, {5{x1}}});
            m0 = lstep(m0);
            m1 = lstep(m1);
        end
        @(negedge clk);
        chk("fvalid0", 32'(if0.fvalid_out), 32'(fv));
        chk("bvalid0", 32'(if0.bvalid_out), 32'(bv));
        chk("fvalid1", 32'(if1.fvalid_out), 32'(fv));
        chk("bvalid1", 32'(if1.bvalid_out), 32'(bv));
        if (fv) begin
            lf0 = fq0.pop_front();
            lf1 = fq1.pop_front();
        end
        if (bv) begin
            lb0 = bq0.pop_front();
            lb1 = bq1.pop_front();
        end
        chk("fout0", 32'(if0.fout), 32'(lf0));
        chk("fout1", 32'(if1.fout), 32'(lf1));
        chk("bout0", 32'({if0.bcontrol, if0.bout}), 32'(lb0));
        chk("bout1", 32'({if1.bcontrol, if1.bout}), 32'(lb1));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_d0"}, 32'({if0.fvalid_out, if0.fout, if0.bvalid_out, if0.bcontrol, if0.bout}), 32'd0);
        chk({tag, "_d1"}, 32'({if1.fvalid_out, if1.fout, if1.bvalid_out, if1.bcontrol, if1.bout}), 32'd0);
    endtask

    logic [2:0] hit;
    logic [2:0] onehot;
    int         pos;

    initial begin
        total = 0;
        bad   = 0;
        hit   = 3'b000;
        model_reset();
        rst_n = 1'b0;
        if0.fvalid_in = 1'b0; if0.fcontrol = 1'b0; if0.fin = 3'b000; if0.bvalid_in = 1'b0; if0.bin = 2'b00;
        if1.fvalid_in = 1'b0; if1.fcontrol = 1'b0; if1.fin = 5'b00000; if1.bvalid_in = 1'b0; if1.bin = 3'b000;
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Forward: majority, minority, and the 5-input boundary at popcount 3 vs 2.
        step(1'b1, 1'b1, 3'b011, 5'b00111, 1'b0, 2'b00, 3'b000);
        chk("tp_maj_d0", 32'(if0.fout), 32'(2'b11));
        chk("tp_maj5_d1", 32'(if1.fout), 32'(3'b111));
        step(1'b1, 1'b0, 3'b011, 5'b00011, 1'b0, 2'b00, 3'b000);
        chk("tp_min_d0", 32'(if0.fout), 32'(2'b00));
        step(1'b1, 1'b1, 3'b000, 5'b00011, 1'b0, 2'b00, 3'b000);
        chk("tp_maj2of5_d1", 32'(if1.fout), 32'(3'b000));
        step(1'b0, 1'b1, 3'b111, 5'b11111, 1'b0, 2'b00, 3'b000);

        // Backward: beat 1, five idle cycles holding the LFSR, beat 2.
        step(1'b0, 1'b0, 3'b000, 5'b00000, 1'b1, 2'b10, 3'b010);
        chk("tp_beat1_bout", 32'(if0.bout), 32'(3'b111));
        chk("tp_beat1_bctl", 32'(if0.bcontrol), 32'(1'b1));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 3'b000, 5'b00000, 1'b0, 2'b01, 3'b101);
        end
        step(1'b0, 1'b0, 3'b000, 5'b00000, 1'b1, 2'b10, 3'b010);
        chk("tp_beat2_bout", 32'(if0.bout), 32'(3'b000));
        chk("tp_beat2_bctl", 32'(if0.bcontrol), 32'(1'b0));
        step(1'b1, 1'b1, 3'b110, 5'b11100, 1'b1, 2'b10, 3'b001);
        step(1'b1, 1'b0, 3'b100, 5'b10000, 1'b1, 2'b01, 3'b100);

        // Reset asserted mid-stream with beats in flight.
        step(1'b1, 1'b1, 3'b111, 5'b11111, 1'b1, 2'b11, 3'b111);
        if0.fvalid_in = 1'b1; if0.bvalid_in = 1'b1;
        if1.fvalid_in = 1'b1; if1.bvalid_in = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'b000, 5'b00000, 1'b0, 2'b00, 3'b000);
        step(1'b0, 1'b0, 3'b000, 5'b00000, 1'b1, 2'b10, 3'b010);
        chk("tp_rst_beat1_bout", 32'(if0.bout), 32'(3'b111));

        // Long mixed run; one-hot gradients on the 5/3 instance reveal every selection index.
        for (int i = 0; i < 300; i++) begin
            pos    = $urandom_range(0, 2);
            onehot = 3'b001 << pos;
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), 1'b1, 2'($urandom_range(0, 3)), onehot);
            if (if1.bvalid_out && if1.bcontrol) hit[pos] = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sel_cover_%0d", i), 32'(hit[i]), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
